// File: rtl/snake_score_bcd.sv
// snake_score_bcd: four-digit BCD score keeper for a snake game.
// It keeps the current score and a high score, runs the high-score
// compare on game over, and drives registered 7-segment digit codes.
// Leading zeros can be shown as the blank code 4'hA.
module snake_score_bcd #(
  parameter int LEAD_BLANK = 1,  // 1: leading zeros shown as 4'hA
  parameter int SAT_EN     = 1   // 1: saturate at 9999, 0: wrap and flag
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iCLR,
  input  logic       iADD,
  input  logic       iGAME_OVER,
  input  logic       iSHOW_HI,
  output logic [3:0] oDIG0,
  output logic [3:0] oDIG1,
  output logic [3:0] oDIG2,
  output logic [3:0] oDIG3,
  output logic       oNEW_HI,
  output logic       oOVF
);

  localparam logic [3:0] BLANK_CODE = 4'hA;
  // Value shown on the upper three digits while reset is held.
  localparam logic [3:0] UPPER_RST  = (LEAD_BLANK != 0) ? BLANK_CODE : 4'h0;

  // Nibble [0] is the ones digit and nibble [3] is the thousands digit.
  logic [3:0][3:0] score_reg, score_next;
  logic [3:0][3:0] hi_reg, hi_next;
  logic            new_hi_reg, new_hi_next;
  logic            ovf_reg, ovf_next;
  logic [3:0][3:0] dig_reg, dig_next;

  // Decimal +1 on the current score, as a ripple of per-digit carries.
  logic [4:0]      carry;
  logic [3:0][3:0] inc_val;
  logic            at_max;
  logic            beats_hi;
  logic [3:0][3:0] disp_src;
  logic [3:1]      lead_zero;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_inc
      // A digit rolls 9 -> 0 and passes the carry on when it receives one.
      assign inc_val[gi]  = carry[gi]
                          ? ((score_reg[gi] == 4'd9) ? 4'd0 : score_reg[gi] + 4'd1)
                          : score_reg[gi];
      assign carry[gi+1]  = carry[gi] && (score_reg[gi] == 4'd9);
    end
  endgenerate

  // A carry out of the thousands digit means the score is 9999.
  assign at_max = carry[4];

  // For valid BCD, the packed 16-bit compare gives the same order as the
  // decimal compare, so no conversion to binary is needed.
  assign beats_hi = (score_reg > hi_reg);

  // Next score and wrap flag. Clear takes priority over add.
  always_comb begin
    score_next = score_reg;
    ovf_next   = ovf_reg;
    if (iCLR) begin
      score_next = '0;
      ovf_next   = 1'b0;
    end else if (iADD) begin
      if (!at_max) begin
        score_next = inc_val;
      end else if (SAT_EN == 0) begin
        score_next = '0;
        ovf_next   = 1'b1;
      end
    end
  end

  // High-score capture uses the pre-update score. A new record sets the flag
  // even if a clear arrives in the same cycle.
  always_comb begin
    hi_next     = hi_reg;
    new_hi_next = new_hi_reg;
    if (iGAME_OVER && beats_hi) begin
      hi_next     = score_reg;
      new_hi_next = 1'b1;
    end else if (iCLR) begin
      new_hi_next = 1'b0;
    end
  end

  // Display source is selected every clock from the registered values.
  assign disp_src = iSHOW_HI ? hi_reg : score_reg;

  // A digit is a leading zero when it and every digit above it are zero.
  assign lead_zero[3] = (disp_src[3] == 4'd0);
  generate
    for (gi = 1; gi < 3; gi++) begin : g_lead
      assign lead_zero[gi] = lead_zero[gi+1] && (disp_src[gi] == 4'd0);
    end
  endgenerate

  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      if (gi == 0) begin : g_ones
        // The ones digit is never blanked, so a zero score still shows "0".
        assign dig_next[gi] = disp_src[gi];
      end else begin : g_upper
        assign dig_next[gi] = ((LEAD_BLANK != 0) && lead_zero[gi])
                            ? BLANK_CODE : disp_src[gi];
      end
    end
  endgenerate

  // Score, high-score and flag state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      score_reg  <= '0;
      hi_reg     <= '0;
      new_hi_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      score_reg  <= score_next;
      hi_reg     <= hi_next;
      new_hi_reg <= new_hi_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Registered digit codes, one edge behind the score registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dig_reg <= {UPPER_RST, UPPER_RST, UPPER_RST, 4'h0};
    end else begin
      dig_reg <= dig_next;
    end
  end

  assign oDIG0   = dig_reg[0];
  assign oDIG1   = dig_reg[1];
  assign oDIG2   = dig_reg[2];
  assign oDIG3   = dig_reg[3];
  assign oNEW_HI = new_hi_reg;
  assign oOVF    = ovf_reg;

endmodule

// File: tb/tb_snake_score_bcd.sv
// tb_snake_score_bcd: self-checking bench for snake_score_bcd.
// Three instances run on the same stimulus: blank+saturate, blank+wrap and
// no-blank+saturate. An integer score model predicts the display, which is
// queued at drive time and popped once the DUT has clocked it out.
module tb_snake_score_bcd;

  localparam int LB_TAB  [3] = '{1, 1, 0};
  localparam int SAT_TAB [3] = '{1, 0, 1};

  logic clk;
  logic rst_n;
  logic i_clr, i_add, i_go, i_show;
  logic [2:0][15:0] obs_dig;
  logic [2:0]       obs_nh;
  logic [2:0]       obs_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      snake_score_bcd #(
        .LEAD_BLANK (LB_TAB[gi]),
        .SAT_EN     (SAT_TAB[gi])
      ) u_dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iCLR       (i_clr),
        .iADD       (i_add),
        .iGAME_OVER (i_go),
        .iSHOW_HI   (i_show),
        .oDIG0      (obs_dig[gi][3:0]),
        .oDIG1      (obs_dig[gi][7:4]),
        .oDIG2      (obs_dig[gi][11:8]),
        .oDIG3      (obs_dig[gi][15:12]),
        .oNEW_HI    (obs_nh[gi]),
        .oOVF       (obs_ovf[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model state per instance.
  int m_score [3];
  int m_hi    [3];
  bit m_nh    [3];
  bit m_ovf   [3];

  logic [2:0][15:0] sb_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Expected digit codes for a decimal value.
  function automatic logic [15:0] disp(input int v, input int lb);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'(v / 1000);
    if (lb != 0) begin
      if (v < 1000) d3 = 4'hA;
      if (v < 100)  d2 = 4'hA;
      if (v < 10)   d1 = 4'hA;
    end
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_score[k] = 0;
      m_hi[k]    = 0;
      m_nh[k]    = 1'b0;
      m_ovf[k]   = 1'b0;
    end
    sb_q.delete();
  endtask

  // One clock of stimulus, with a full per-instance check after the edge.
  task automatic step(input logic clr, input logic add, input logic go, input logic show);
    logic [2:0][15:0] e;
    @(negedge clk);
    i_clr  = clr;
    i_add  = add;
    i_go   = go;
    i_show = show;
    for (int k = 0; k < 3; k++)
      e[k] = disp(show ? m_hi[k] : m_score[k], LB_TAB[k]);
    sb_q.push_back(e);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (go && (m_score[k] > m_hi[k])) begin
        m_hi[k] = m_score[k];
        m_nh[k] = 1'b1;
      end else if (clr) begin
        m_nh[k] = 1'b0;
      end
      if (clr) begin
        m_score[k] = 0;
        m_ovf[k]   = 1'b0;
      end else if (add) begin
        if (m_score[k] == 9999) begin
          if (SAT_TAB[k] == 0) begin
            m_score[k] = 0;
            m_ovf[k]   = 1'b1;
          end
        end else begin
          m_score[k] = m_score[k] + 1;
        end
      end
    end
    #1;
    cyc++;
    e = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("dig_u%0d_cyc%0d", k, cyc), obs_dig[k], e[k]);
      check_val($sformatf("nh_u%0d_cyc%0d", k, cyc), 16'(obs_nh[k]), 16'(m_nh[k]));
      check_val($sformatf("ovf_u%0d_cyc%0d", k, cyc), 16'(obs_ovf[k]), 16'(m_ovf[k]));
    end
  endtask

  // Pulse reset between clock edges and check that outputs react at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s_dig_u%0d", tag, k), obs_dig[k],
                (LB_TAB[k] != 0) ? 16'hAAA0 : 16'h0000);
      check_val($sformatf("%s_nh_u%0d", tag, k), 16'(obs_nh[k]), 16'h0);
      check_val($sformatf("%s_ovf_u%0d", tag, k), 16'(obs_ovf[k]), 16'h0);
    end
    model_reset();
    i_clr  = 1'b0;
    i_add  = 1'b0;
    i_go   = 1'b0;
    i_show = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b1;
    i_clr  = 1'b0;
    i_add  = 1'b0;
    i_go   = 1'b0;
    i_show = 1'b0;
    model_reset();
    #2;
    do_reset("rst0");

    // Three adds, display two edges after the last one.
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r23_blank", obs_dig[0], 16'hAAA3);
    check_val("r23_noblank", obs_dig[2], 16'h0003);

    // Record 30, then 42 beats it; clear with high-score display.
    step(1, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (42) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check_val("r26_newhi", 16'(obs_nh[0]), 16'h1);
    step(1, 0, 0, 1);
    check_val("r26_hidisp", obs_dig[0], 16'hAA42);
    check_val("r26_nhclr", 16'(obs_nh[0]), 16'h0);

    // Clear wins over add.
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r27_clrwin", obs_dig[0], 16'hAAA0);

    // Game over with add at 7 against record 7: no new record, add applies.
    do_reset("rst1");
    repeat (7) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check_val("r27_score8", obs_dig[0], 16'hAAA8);
    check_val("r27_nh0", 16'(obs_nh[0]), 16'h0);
    step(0, 0, 0, 1);
    check_val("r27_hi7", obs_dig[0], 16'hAAA7);

    // Decimal carry across digit boundaries.
    step(1, 0, 0, 0);
    repeat (99) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r24_99", obs_dig[0], 16'hAA99);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r24_100", obs_dig[0], 16'hA100);
    repeat (899) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r24_999", obs_dig[0], 16'hA999);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r24_1000", obs_dig[0], 16'h1000);

    // Top of range: saturate versus wrap.
    repeat (8999) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r25_9999", obs_dig[1], 16'h9999);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r25_sat", obs_dig[0], 16'h9999);
    check_val("r25_sat_ovf", 16'(obs_ovf[0]), 16'h0);
    check_val("r25_wrap", obs_dig[1], 16'hAAA0);
    check_val("r25_wrap_ovf", 16'(obs_ovf[1]), 16'h1);

    // Mid-cycle reset at 0123 with the wrap flag set.
    repeat (123) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r28_pre", obs_dig[1], 16'hA123);
    do_reset("r28");

    // First add after reset release is honoured.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("r22_first", obs_dig[0], 16'hAAA1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
